// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared types, limits and helpers for the time_keeper block.
//   bcd_digit_t   : one BCD digit (4 bits)
//   time_field_t  : one two-digit BCD field (hh, mm or ss)
//   state_t       : control FSM state (IDLE / LOAD / ADV)
// ----------------------------------------------------------------------------
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] time_field_t;

  localparam time_field_t MAX_SS   = 8'h59;
  localparam time_field_t MAX_MM   = 8'h59;
  localparam time_field_t MAX_HH24 = 8'h23;
  localparam time_field_t MAX_HH12 = 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADV  = 2'd2
  } state_t;

  // Two-digit BCD increment; the units digit wraps 9 -> 0 with a tens carry.
  function automatic time_field_t bcd_inc(input time_field_t v);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

  function automatic logic is_bcd(input time_field_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Legal BCD and inside [lo, hi]; for valid BCD the binary compare
  // orders the same way as the decimal value.
  function automatic logic field_ok(input time_field_t v,
                                    input time_field_t lo,
                                    input time_field_t hi);
    return is_bcd(v) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter: counts MIN_VAL .. WRAP_VAL and wraps back to MIN_VAL.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (value -> RST_VAL)
//   inc        : advance by one this cycle
//   load       : write load_val this cycle (takes priority over inc)
//   load_val   : value to load
//   value      : current count
//   carry      : combinational, high when inc is applied at WRAP_VAL
// ----------------------------------------------------------------------------
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter time_field_t WRAP_VAL = MAX_SS,
  parameter time_field_t MIN_VAL  = 8'h00,
  parameter time_field_t RST_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  time_field_t load_val,
  output time_field_t value,
  output logic        carry
);

  time_field_t value_q;

  assign carry = inc && (value_q == WRAP_VAL);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RST_VAL;
    end else if (load) begin
      value_q <= load_val;
    end else if (inc) begin
      value_q <= carry ? MIN_VAL : bcd_inc(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/time_keeper.sv
// ----------------------------------------------------------------------------
// time_keeper
// BCD time-of-day keeper advanced by a 1 Hz square wave from a clock divider.
// Build option: define TIME_12H_EN for 12-hour mode (hours 12, 01..11, pm
// flag and pm port); without it the clock runs 00..23 and pm is absent.
// Parameter:
//   SYNC_STAGES : synchronizer depth on clk_1Hz (legal 2..4)
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   clk_1Hz             : asynchronous 1 Hz square wave; rising edge = 1 s
//   set_valid           : load request, held until accepted
//   set_hh/mm/ss        : BCD load values
//   set_ready           : load can be accepted this cycle
//   set_err             : one-cycle pulse after a rejected (out-of-range) load
//   hh, mm, ss          : current time in BCD
//   sec_tick            : one-cycle pulse in the cycle after ss advanced
//   pm                  : PM flag (TIME_12H_EN only)
// ----------------------------------------------------------------------------
module time_keeper
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_1Hz,
  input  logic        set_valid,
  input  time_field_t set_hh,
  input  time_field_t set_mm,
  input  time_field_t set_ss,
  output logic        set_ready,
  output logic        set_err,
  output time_field_t hh,
  output time_field_t mm,
  output time_field_t ss,
  output logic        sec_tick
`ifdef TIME_12H_EN
  ,
  output logic        pm
`endif
);

`ifdef TIME_12H_EN
  localparam time_field_t HH_MIN = 8'h01;
  localparam time_field_t HH_MAX = MAX_HH12;
  localparam time_field_t HH_RST = 8'h12;
`else
  localparam time_field_t HH_MIN = 8'h00;
  localparam time_field_t HH_MAX = MAX_HH24;
  localparam time_field_t HH_RST = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // clk_1Hz synchronizer and rising-edge detector.
  // vld_q tracks which stages hold samples taken after reset; an edge is only
  // reported when both compared samples are post-reset, so a level that was
  // already high (or in flight) across reset is never seen as a new edge.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   prev_q;
  logic                   adv_strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign adv_strobe = sync_q[SYNC_STAGES-1] & ~prev_q & vld_q[SYNC_STAGES];

  // --------------------------------------------------------------------------
  // Load handshake and range check
  // --------------------------------------------------------------------------
  logic set_legal;
  logic load_req;
  logic do_load;
  logic do_inc;
  logic set_err_q;

  assign set_ready = ~rst;
  assign set_legal = field_ok(set_ss, 8'h00, MAX_SS) &&
                     field_ok(set_mm, 8'h00, MAX_MM) &&
                     field_ok(set_hh, HH_MIN, HH_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= load_req && !set_legal;
    end
  end

  assign set_err = set_err_q;

  // --------------------------------------------------------------------------
  // Control FSM. The write or advance happens on the edge that enters LOAD or
  // ADV, so ss changes SYNC_STAGES+1 cycles after clk_1Hz rises; the state
  // then marks that one cycle (ADV drives sec_tick) before returning to IDLE.
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      // A held set_valid or a strobe right after ADV is taken directly,
      // so all states share the same exit decision.
      ST_IDLE, ST_LOAD, ST_ADV: begin
        if (do_load) begin
          state_d = ST_LOAD;
        end else if (do_inc) begin
          state_d = ST_ADV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A legal load beats a coincident strobe and discards it; a rejected load
  // does not block the advance.
  always_comb begin
    load_req = set_valid && set_ready;
    do_load  = load_req && set_legal;
    do_inc   = adv_strobe && !do_load;
    sec_tick = (state_q == ST_ADV);
  end

  // --------------------------------------------------------------------------
  // Time fields: ss -> mm -> hh carry ripple within one cycle
  // --------------------------------------------------------------------------
  logic ss_carry;
  logic mm_carry;
  logic hh_carry_unused;

  bcd_mod_counter #(
    .WRAP_VAL (MAX_SS),
    .MIN_VAL  (8'h00),
    .RST_VAL  (8'h00)
  ) u_ss (
    .clk      (clk),
    .rst      (rst),
    .inc      (do_inc),
    .load     (do_load),
    .load_val (set_ss),
    .value    (ss),
    .carry    (ss_carry)
  );

  bcd_mod_counter #(
    .WRAP_VAL (MAX_MM),
    .MIN_VAL  (8'h00),
    .RST_VAL  (8'h00)
  ) u_mm (
    .clk      (clk),
    .rst      (rst),
    .inc      (ss_carry),
    .load     (do_load),
    .load_val (set_mm),
    .value    (mm),
    .carry    (mm_carry)
  );

  bcd_mod_counter #(
    .WRAP_VAL (HH_MAX),
    .MIN_VAL  (HH_MIN),
    .RST_VAL  (HH_RST)
  ) u_hh (
    .clk      (clk),
    .rst      (rst),
    .inc      (mm_carry),
    .load     (do_load),
    .load_val (set_hh),
    .value    (hh),
    .carry    (hh_carry_unused)
  );

`ifdef TIME_12H_EN
  // pm flips when 11:59:59 rolls into 12:00:00; a load leaves it unchanged.
  logic pm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q <= 1'b0;
    end else if (mm_carry && (hh == 8'h11)) begin
      pm_q <= ~pm_q;
    end
  end

  assign pm = pm_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// ----------------------------------------------------------------------------
// tb_time_keeper
// Directed self-checking bench for time_keeper. Inputs change on the falling
// edge of clk and outputs are sampled there too, half a cycle after the
// rising edge that updates them. The 1 Hz input is scaled: one "second" of
// clk_1Hz is 100 clk cycles (50 high, 50 low).
// ----------------------------------------------------------------------------
module tb_time_keeper;
  import clock_pkg::*;

  localparam int S = 2;

`ifdef TIME_12H_EN
  localparam time_field_t RST_HH = 8'h12;
  localparam time_field_t BAD_HH = 8'h00;
`else
  localparam time_field_t RST_HH = 8'h00;
  localparam time_field_t BAD_HH = 8'h24;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_1Hz;
  logic        set_valid;
  time_field_t set_hh, set_mm, set_ss;
  logic        set_ready;
  logic        set_err;
  time_field_t hh, mm, ss;
  logic        sec_tick;
`ifdef TIME_12H_EN
  logic        pm;
`endif

  int checks = 0;
  int errors = 0;
  int ticks;
  int bad_digits;

  always #5 clk = ~clk;

  time_keeper #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1Hz   (clk_1Hz),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_ready (set_ready),
    .set_err   (set_err),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .sec_tick  (sec_tick)
`ifdef TIME_12H_EN
    ,
    .pm        (pm)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One cycle, tallying sec_tick pulses and any A-F digit on the outputs.
  task automatic watch_cycle();
    step(1);
    if (sec_tick) ticks++;
    if (!is_bcd(hh) || !is_bcd(mm) || !is_bcd(ss)) bad_digits++;
  endtask

  task automatic load_time(input time_field_t h, input time_field_t m, input time_field_t s);
    set_hh    = h;
    set_mm    = m;
    set_ss    = s;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
  endtask

  task automatic check_time(input string tag, input time_field_t h,
                            input time_field_t m, input time_field_t s);
    check({tag, ".hh"}, {24'd0, hh}, {24'd0, h});
    check({tag, ".mm"}, {24'd0, mm}, {24'd0, m});
    check({tag, ".ss"}, {24'd0, ss}, {24'd0, s});
  endtask

  initial begin
    rst       = 1'b1;
    clk_1Hz   = 1'b0;
    set_valid = 1'b0;
    set_hh    = 8'h00;
    set_mm    = 8'h00;
    set_ss    = 8'h00;

    // ---- reset state ----
    step(2);
    check_time("reset", RST_HH, 8'h00, 8'h00);
    check("reset.sec_tick", sec_tick, 0);
    check("reset.set_err", set_err, 0);
    check("reset.set_ready", set_ready, 0);
`ifdef TIME_12H_EN
    check("reset.pm", pm, 0);
`endif
    rst = 1'b0;
    step(1);
    check("post_reset.set_ready", set_ready, 1);
    step(4);

    // ---- first edge: ss advances exactly S+1 cycles after clk_1Hz rises ----
    clk_1Hz = 1'b1;
    step(S);
    check("lat.ss_before", ss, 8'h00);
    check("lat.tick_before", sec_tick, 0);
    step(1);
    check("lat.ss_after", ss, 8'h01);
    check("lat.tick_pulse", sec_tick, 1);
    step(1);
    check("lat.tick_end", sec_tick, 0);
    clk_1Hz = 1'b0;
    step(10);
    check("fall_edge.ss", ss, 8'h01);

    // ---- rollover ----
`ifdef TIME_12H_EN
    load_time(8'h11, 8'h59, 8'h59);
    check_time("load11", 8'h11, 8'h59, 8'h59);
    check("load11.pm", pm, 0);
    clk_1Hz = 1'b1;
    step(S + 1);
    check_time("roll12", 8'h12, 8'h00, 8'h00);
    check("roll12.pm", pm, 1);
    clk_1Hz = 1'b0;
    step(5);
    load_time(8'h12, 8'h00, 8'h00);
`else
    load_time(8'h23, 8'h59, 8'h59);
    check_time("load23", 8'h23, 8'h59, 8'h59);
    check("load23.set_err", set_err, 0);
    clk_1Hz = 1'b1;
    step(S + 1);
    check_time("roll24", 8'h00, 8'h00, 8'h00);
    check("roll24.tick", sec_tick, 1);
    clk_1Hz = 1'b0;
    step(5);
`endif

    // ---- illegal loads: set_err pulses once, time unchanged ----
    load_time(8'h10, 8'h60, 8'h00);
    check("bad_mm.set_err", set_err, 1);
    check_time("bad_mm", RST_HH, 8'h00, 8'h00);
    step(1);
    check("bad_mm.set_err_end", set_err, 0);
    load_time(8'h10, 8'h20, 8'h1A);
    check("bad_ss.set_err", set_err, 1);
    check_time("bad_ss", RST_HH, 8'h00, 8'h00);
    step(1);
    check("bad_ss.set_err_end", set_err, 0);
    load_time(BAD_HH, 8'h00, 8'h00);
    check("bad_hh.set_err", set_err, 1);
    check_time("bad_hh", RST_HH, 8'h00, 8'h00);

    // ---- load coincident with the advance strobe: load wins, no tick ----
    step(2);
    clk_1Hz = 1'b1;
    step(S);
    load_time(8'h10, 8'h20, 8'h30);
    check_time("coinc", 8'h10, 8'h20, 8'h30);
    check("coinc.tick", sec_tick, 0);
    step(1);
    check("coinc.tick_next", sec_tick, 0);
    check("coinc.ss_next", ss, 8'h30);
    clk_1Hz = 1'b0;
    step(5);

    // ---- held set_valid across an edge: reloads, no advance ----
    set_hh    = 8'h01;
    set_mm    = 8'h02;
    set_ss    = 8'h03;
    set_valid = 1'b1;
    clk_1Hz   = 1'b1;
    ticks     = 0;
    for (int i = 0; i < 8; i++) watch_cycle();
    set_valid = 1'b0;
    for (int i = 0; i < 4; i++) watch_cycle();
    check_time("held", 8'h01, 8'h02, 8'h03);
    check("held.ticks", ticks, 0);
    clk_1Hz = 1'b0;
    step(5);

    // ---- reset while an edge is in the synchronizer ----
    clk_1Hz = 1'b1;
    step(1);
    rst = 1'b1;
    step(2);
    rst   = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) watch_cycle();
    check_time("rst_flight", RST_HH, 8'h00, 8'h00);
    check("rst_flight.ticks", ticks, 0);
`ifdef TIME_12H_EN
    check("rst_flight.pm", pm, 0);
`endif
    clk_1Hz = 1'b0;

    // ---- 3 s low, then 100 edges ----
    step(300);
    check_time("idle3s", RST_HH, 8'h00, 8'h00);
    ticks      = 0;
    bad_digits = 0;
    for (int e = 0; e < 100; e++) begin
      clk_1Hz = 1'b1;
      for (int c = 0; c < 50; c++) watch_cycle();
      clk_1Hz = 1'b0;
      for (int c = 0; c < 50; c++) watch_cycle();
    end
    check_time("run100", RST_HH, 8'h01, 8'h40);
    check("run100.ticks", ticks, 100);
    check("run100.bad_digits", bad_digits, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
